// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// Memory stage of the pipeline. Performs 32-bit loads and stores against a
// 16-bit asynchronous SRAM as two sequential half-word accesses (low half
// first). ready is held low while an access is in flight so that the
// hazard/freeze logic stalls the pipeline, including the MEM/WB register.
//
// Ports:
//   clk        pipeline clock
//   rst        asynchronous, active-low reset
//   MEM_R_EN   load request from EXE/MEM
//   MEM_W_EN   store request from EXE/MEM (wins when both are high)
//   ALU_Res    byte address from EXE/MEM
//   Val_Rm     store data
//   memData    registered load result to MEM/WB
//   ready      high when no access is pending or one completes this cycle
//   SRAM_DQ    bidirectional SRAM data bus
//   SRAM_ADDR  SRAM half-word address
//   SRAM_WE_N  SRAM write enable, active-low
//   SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  tied low
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] memData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r, state_nx_s;
  logic [CW-1:0]  cnt_r, cnt_nx_s;
  logic [16:0]    word_r, word_nx_s;
  logic           wr_r, wr_nx_s;
  logic [31:0]    data_r, data_nx_s;
  logic [15:0]    lo_r;
  logic [17:0]    addr_r, addr_nx_s;
  logic           we_n_r, we_n_nx_s;
  logic           dq_oe_r, dq_oe_nx_s;
  logic [15:0]    dq_out_r, dq_out_nx_s;
  logic [16:0]    word_in_s;
  logic           req_s;
  logic           last_s;

  // Wrap-around offset from the SRAM base, reduced to a 32-bit word index.
  assign word_in_s = 17'((ALU_Res - 32'(BASE_ADDR)) >> 2);
  assign req_s     = MEM_R_EN | MEM_W_EN;
  assign last_s    = (cnt_r == LAST);

  // ready must be high throughout reset, even if a request is already present.
  assign ready = ~rst | (state_r == DONE) | ((state_r == IDLE) & ~req_s);

  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
  assign SRAM_ADDR = addr_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Next-state, counter and latched request, plus next values of the bus outputs.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    word_nx_s   = word_r;
    wr_nx_s     = wr_r;
    data_nx_s   = data_r;
    addr_nx_s   = addr_r;
    we_n_nx_s   = 1'b1;
    dq_oe_nx_s  = 1'b0;
    dq_out_nx_s = dq_out_r;

    case (state_r)
      IDLE: begin
        if (req_s) begin
          // A simultaneous read is dropped: the store takes priority.
          wr_nx_s    = MEM_W_EN;
          word_nx_s  = word_in_s;
          data_nx_s  = Val_Rm;
          state_nx_s = LO;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      LO: begin
        if (last_s) begin
          state_nx_s = HI;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HI: begin
        if (last_s) begin
          state_nx_s = DONE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        // The request is still asserted here; never restart from DONE.
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase

    // Bus outputs are registered, so they are derived from next-state values
    // to line up with the state they belong to. WE_N rises on the last cycle
    // of each half so address and data stay stable around the rising edge.
    if (state_nx_s == LO) begin
      addr_nx_s   = {word_nx_s, 1'b0};
      dq_out_nx_s = data_nx_s[15:0];
      dq_oe_nx_s  = wr_nx_s;
      we_n_nx_s   = ~(wr_nx_s & (cnt_nx_s != LAST));
    end else if (state_nx_s == HI) begin
      addr_nx_s   = {word_nx_s, 1'b1};
      dq_out_nx_s = data_nx_s[31:16];
      dq_oe_nx_s  = wr_nx_s;
      we_n_nx_s   = ~(wr_nx_s & (cnt_nx_s != LAST));
    end else begin
      dq_oe_nx_s = 1'b0;
      we_n_nx_s  = 1'b1;
    end
  end

  // State, request latch and registered SRAM bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      word_r   <= 17'd0;
      wr_r     <= 1'b0;
      data_r   <= 32'd0;
      addr_r   <= 18'd0;
      we_n_r   <= 1'b1;
      dq_oe_r  <= 1'b0;
      dq_out_r <= 16'd0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      word_r   <= word_nx_s;
      wr_r     <= wr_nx_s;
      data_r   <= data_nx_s;
      addr_r   <= addr_nx_s;
      we_n_r   <= we_n_nx_s;
      dq_oe_r  <= dq_oe_nx_s;
      dq_out_r <= dq_out_nx_s;
    end
  end

  // Read capture: low half on the last LO cycle, full word on the last HI cycle
  // so memData is already valid in DONE. Stores leave memData untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_r    <= 16'd0;
      memData <= 32'd0;
    end else begin
      if ((state_r == LO) && last_s && !wr_r) begin
        lo_r <= SRAM_DQ;
      end
      if ((state_r == HI) && last_s && !wr_r) begin
        memData <= {SRAM_DQ, lo_r};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: behavioural SRAM model,
// independent reference memory and a scoreboard of expected load results.
module tb_mem_stage_sram_ctrl;

  localparam int AC   = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic [31:0] mem_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  logic [15:0] sram    [0:262143];
  logic [15:0] ref_mem [0:262143];
  logic        rd_active;
  logic [31:0] sb_q [$];
  logic [31:0] exp_md;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .ALU_Res(alu_res), .Val_Rm(val_rm), .memData(mem_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  // SRAM model: drives the bus only while the bench knows a load is running.
  assign sram_dq = (rd_active && sram_we_n) ? sram[sram_addr] : 16'hzzzz;

  always @(posedge sram_we_n) begin
    if (rst) sram[sram_addr] = sram_dq;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one request starting just after a rising edge and checks every
  // cycle up to and including DONE; returns just after the next rising edge
  // with the request still applied (caller decides what comes next).
  task automatic run_op(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic [16:0] word;
    logic [31:0] got_exp;
    int half, phase;
    word     = 17'((addr - 32'(BASE)) >> 2);
    mem_r_en = r;
    mem_w_en = w;
    alu_res  = addr;
    val_rm   = data;
    rd_active = r && !w;
    if (w) begin
      ref_mem[{word, 1'b0}] = data[15:0];
      ref_mem[{word, 1'b1}] = data[31:16];
    end else if (r) begin
      exp_md = {ref_mem[{word, 1'b1}], ref_mem[{word, 1'b0}]};
    end else begin
      exp_md = exp_md;
    end
    sb_q.push_back(exp_md);
    for (int c = 0; c <= 2*AC+1; c++) begin
      @(negedge clk);
      check_eq("ready", {31'd0, ready}, {31'd0, (c == 2*AC+1)});
      if (c >= 1 && c <= 2*AC) begin
        half  = (c - 1) / AC;
        phase = (c - 1) % AC;
        check_eq("sram_addr", {14'd0, sram_addr}, {14'd0, word, half[0]});
        check_eq("we_n", {31'd0, sram_we_n}, {31'd0, !(w && phase < AC-1)});
      end
      if (c == 2*AC+1) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
          got_exp = sb_q.pop_front();
          check_eq("memData", mem_data, got_exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    rd_active = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_ready", {31'd0, ready}, 32'd1);
      check_eq("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0;
    alu_res = 32'd0; val_rm = 32'd0; rd_active = 1'b0; exp_md = 32'd0;
    ref_mem[6] = 16'h0002; ref_mem[7] = 16'h0001;
    sram[6]    = 16'h0002; sram[7]    = 16'h0001;
    // Reset with a request present: ready still high, outputs at reset values.
    @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_memData", mem_data, 32'd0);
    check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("rst_addr", {14'd0, sram_addr}, 32'd0);
    mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(10);

    // Store, then read back with the request held through DONE, then the next word.
    run_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    idle(2);
    check_eq("sram4", {16'd0, sram[4]}, 32'h0000BEEF);
    check_eq("sram5", {16'd0, sram[5]}, 32'h0000DEAD);
    run_op(1'b1, 1'b0, 32'd1032, 32'd0);
    run_op(1'b1, 1'b0, 32'd1032, 32'd0);
    run_op(1'b1, 1'b0, 32'd1036, 32'd0);
    idle(2);

    // Address below the base wraps to the top of the SRAM.
    run_op(1'b0, 1'b1, 32'h000003FC, 32'h12345678);
    idle(1);
    check_eq("sram_3fffe", {16'd0, sram[18'h3FFFE]}, 32'h00005678);
    check_eq("sram_3ffff", {16'd0, sram[18'h3FFFF]}, 32'h00001234);
    run_op(1'b1, 1'b0, 32'h000003FC, 32'd0);

    // Both enables: behaves as a store, memData holds the previous load.
    run_op(1'b1, 1'b1, 32'd1040, 32'hA5A55A5A);
    run_op(1'b1, 1'b0, 32'd1040, 32'd0);
    idle(1);

    // Reset in cycle 2 of a store: only the low half has been written.
    mem_r_en = 1'b0; mem_w_en = 1'b1; alu_res = 32'd1032; val_rm = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    check_eq("abort_memData", mem_data, 32'd0);
    mem_w_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    ref_mem[4] = 16'hF00D;
    exp_md = 32'd0;
    idle(3);
    check_eq("abort_sram4", {16'd0, sram[4]}, 32'h0000F00D);
    check_eq("abort_sram5", {16'd0, sram[5]}, 32'h0000DEAD);
    run_op(1'b1, 1'b0, 32'd1032, 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
